stack_engine: RTL and testbench

//   Parametrised operand stack for the stack CPU datapath. Replaces the fixed-size stack logic in cpu.

---
 rtl/stack_engine.sv | 181 ++++++++++++++++++
 tb/tb_stack_engine.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/stack_engine.sv
// stack_engine: parametrised operand stack for the stack CPU datapath.
// Executes one command per clock (NOP, PUSH, POP, DUP, SWAP, OVER, BINOP, CLEAR).
// It exposes the top two entries to the ALU, and occupancy and error flags to the control unit.
//
// Optional feature macro: STACK_PEEK_EN adds a combinational random-access peek port.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low
//   op_valid   command strobe; op is ignored when low
//   op         command code
//   din        data for PUSH / BINOP
//   tos, nos   entry 0 / entry 1, forced to 0 when not present
//   count      occupancy 0..DEPTH
//   empty      count == 0
//   full       count == DEPTH
//   err        one-cycle pulse after a rejected command
//   err_ovf    sticky overflow flag (cleared by CLEAR or reset)
//   err_unf    sticky underflow flag (cleared by CLEAR or reset)
//   peek_idx   (STACK_PEEK_EN) entry index, 0 = TOS
//   peek_data  (STACK_PEEK_EN) entry data, 0 when out of range
//   peek_oob   (STACK_PEEK_EN) peek_idx >= count
module stack_engine #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             err,
  output logic             err_ovf,
  output logic             err_unf
`ifdef STACK_PEEK_EN
  ,
  input  logic [CW-1:0]    peek_idx,
  output logic [WIDTH-1:0] peek_data,
  output logic             peek_oob
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    OpNop   = 3'b000,
    OpPush  = 3'b001,
    OpPop   = 3'b010,
    OpDup   = 3'b011,
    OpSwap  = 3'b100,
    OpOver  = 3'b101,
    OpBinop = 3'b110,
    OpClear = 3'b111
  } op_e;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  op_e              op_dec;
  logic [CW-1:0]    need;
  logic             grows;
  logic             is_full;
  logic [AW-1:0]    idx_push;  // first free slot
  logic [AW-1:0]    idx_top;   // entry 0
  logic [AW-1:0]    idx_nxt;   // entry 1

  assign op_dec   = op_e'(op);
  assign is_full  = (count_q == CW'(DEPTH));
  // Truncating casts are safe: each index is only used when the entry exists.
  assign idx_push = AW'(count_q);
  assign idx_top  = AW'(count_q - CW'(1));
  assign idx_nxt  = AW'(count_q - CW'(2));

  // Required occupancy and whether the command grows the stack.
  always_comb begin
    need  = '0;
    grows = 1'b0;
    unique case (op_dec)
      OpNop:   need = CW'(0);
      OpPush:  begin need = CW'(0); grows = 1'b1; end
      OpPop:   need = CW'(1);
      OpDup:   begin need = CW'(1); grows = 1'b1; end
      OpSwap:  need = CW'(2);
      OpOver:  begin need = CW'(2); grows = 1'b1; end
      OpBinop: need = CW'(2);
      OpClear: need = CW'(0);
      default: need = CW'(0);
    endcase
  end

  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    err_d   = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (op_valid) begin
      if (op_dec == OpClear) begin
        count_d = '0;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
      end else if (count_q < need) begin
        // Underflow is checked first so it wins over overflow.
        err_d = 1'b1;
        unf_d = 1'b1;
      end else if (grows && is_full) begin
        err_d = 1'b1;
        ovf_d = 1'b1;
      end else begin
        unique case (op_dec)
          OpPush: begin
            mem_d[idx_push] = din;
            count_d         = count_q + CW'(1);
          end
          OpPop: count_d = count_q - CW'(1);
          OpDup: begin
            mem_d[idx_push] = mem_q[idx_top];
            count_d         = count_q + CW'(1);
          end
          OpSwap: begin
            mem_d[idx_top] = mem_q[idx_nxt];
            mem_d[idx_nxt] = mem_q[idx_top];
          end
          OpOver: begin
            mem_d[idx_push] = mem_q[idx_nxt];
            count_d         = count_q + CW'(1);
          end
          OpBinop: begin
            mem_d[idx_nxt] = din;
            count_d        = count_q - CW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Popped slots keep stale data; mask anything above the live region.
  assign tos     = (count_q >= CW'(1)) ? mem_q[idx_top] : '0;
  assign nos     = (count_q >= CW'(2)) ? mem_q[idx_nxt] : '0;
  assign count   = count_q;
  assign empty   = (count_q == '0);
  assign full    = is_full;
  assign err     = err_q;
  assign err_ovf = ovf_q;
  assign err_unf = unf_q;

`ifdef STACK_PEEK_EN
  logic [AW-1:0] idx_peek;
  assign idx_peek  = AW'(count_q - CW'(1) - peek_idx);
  assign peek_oob  = (peek_idx >= count_q);
  assign peek_data = peek_oob ? '0 : mem_q[idx_peek];
`endif

endmodule

// File: tb/tb_stack_engine.sv
module tb_stack_engine;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  localparam logic [2:0] NOP = 3'b000, PUSH = 3'b001, POP = 3'b010, DUP = 3'b011;
  localparam logic [2:0] SWAP = 3'b100, OVER = 3'b101, BINOP = 3'b110, CLEAR = 3'b111;

  logic             clk = 1'b0;
  logic             rst;
  logic             op_valid;
  logic [2:0]       op;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] tos, nos;
  logic [CW-1:0]    count;
  logic             empty, full, err, err_ovf, err_unf;
`ifdef STACK_PEEK_EN
  logic [CW-1:0]    peek_idx;
  logic [WIDTH-1:0] peek_data;
  logic             peek_oob;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  stack_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op       (op),
    .din      (din),
    .tos      (tos),
    .nos      (nos),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .err      (err),
    .err_ovf  (err_ovf),
    .err_unf  (err_unf)
`ifdef STACK_PEEK_EN
    ,
    .peek_idx (peek_idx),
    .peek_data(peek_data),
    .peek_oob (peek_oob)
`endif
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Full state check: count, tos, nos, err, err_ovf, err_unf (+ empty/full derived).
  task automatic check_state(input string tag, input int c, input int t, input int n,
                             input int e, input int ov, input int un);
    check({tag, ".count"}, int'(count), c);
    check({tag, ".tos"}, int'(tos), t);
    check({tag, ".nos"}, int'(nos), n);
    check({tag, ".err"}, int'(err), e);
    check({tag, ".err_ovf"}, int'(err_ovf), ov);
    check({tag, ".err_unf"}, int'(err_unf), un);
    check({tag, ".empty"}, int'(empty), (c == 0) ? 1 : 0);
    check({tag, ".full"}, int'(full), (c == int'(DEPTH)) ? 1 : 0);
  endtask

  // Drive a command on the falling edge, apply it on the next rising edge, settle 1.
  task automatic cmd(input logic v, input logic [2:0] o, input logic [WIDTH-1:0] d);
    @(negedge clk);
    op_valid = v;
    op       = o;
    din      = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; op_valid = 1'b0; op = NOP; din = '0;
`ifdef STACK_PEEK_EN
    peek_idx = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    cmd(1'b1, PUSH, 8'h55);
    check_state("pre_push", 1, 'h55, 0, 0, 0, 0);

    // Reset asserted while a PUSH is presented: abort, no partial update.
    @(negedge clk);
    op_valid = 1'b1; op = PUSH; din = 8'h66;
    #2 rst = 1'b0;
    #1;
    check_state("async_rst", 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check_state("rst_held", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    op_valid = 1'b0;
    rst = 1'b1;

    cmd(1'b1, PUSH, 8'h11);
    cmd(1'b1, PUSH, 8'h22);
    cmd(1'b1, PUSH, 8'h33);
    check_state("push3", 3, 'h33, 'h22, 0, 0, 0);
    cmd(1'b0, PUSH, 8'hEE);
    check_state("invalid_ignored", 3, 'h33, 'h22, 0, 0, 0);
    cmd(1'b1, SWAP, 8'h00);
    check_state("swap", 3, 'h22, 'h33, 0, 0, 0);
    cmd(1'b1, OVER, 8'h00);
    check_state("over_full", 4, 'h33, 'h22, 0, 0, 0);

    cmd(1'b1, PUSH, 8'h44);
    check_state("push_ovf", 4, 'h33, 'h22, 1, 1, 0);
    cmd(1'b1, NOP, 8'h00);
    check_state("err_one_cycle", 4, 'h33, 'h22, 0, 1, 0);
    cmd(1'b1, DUP, 8'h00);
    check_state("dup_ovf", 4, 'h33, 'h22, 1, 1, 0);
    cmd(1'b1, CLEAR, 8'h00);
    check_state("clear", 0, 0, 0, 0, 0, 0);

    cmd(1'b1, POP, 8'h00);
    check_state("pop_unf", 0, 0, 0, 1, 0, 1);
    cmd(1'b1, PUSH, 8'h05);
    check_state("unf_sticky", 1, 'h05, 0, 0, 0, 1);
    cmd(1'b1, BINOP, 8'h99);
    check_state("binop_unf", 1, 'h05, 0, 1, 0, 1);
    cmd(1'b1, CLEAR, 8'h00);
    check_state("clear2", 0, 0, 0, 0, 0, 0);

    cmd(1'b1, PUSH, 8'h03);
    cmd(1'b1, PUSH, 8'h04);
    cmd(1'b1, BINOP, 8'h07);
    check_state("binop", 1, 'h07, 0, 0, 0, 0);
    cmd(1'b1, DUP, 8'h00);
    check_state("dup", 2, 'h07, 'h07, 0, 0, 0);
    cmd(1'b1, POP, 8'h00);
    check_state("pop1", 1, 'h07, 0, 0, 0, 0);
    cmd(1'b1, POP, 8'h00);
    check_state("pop2", 0, 0, 0, 0, 0, 0);

`ifdef STACK_PEEK_EN
    cmd(1'b1, PUSH, 8'hA0);
    cmd(1'b1, PUSH, 8'hB0);
    op_valid = 1'b0;
    peek_idx = CW'(0);
    #1;
    check("peek0.data", int'(peek_data), 'hB0);
    check("peek0.oob", int'(peek_oob), 0);
    peek_idx = CW'(1);
    #1;
    check("peek1.data", int'(peek_data), 'hA0);
    check("peek1.oob", int'(peek_oob), 0);
    peek_idx = CW'(2);
    #1;
    check("peek2.data", int'(peek_data), 0);
    check("peek2.oob", int'(peek_oob), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
